// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S conversion scheduler.
package a2d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_WAIT1, ST_GAP, ST_READ, ST_WAIT2, ST_UPD
  } state_t;

  typedef enum logic [1:0] {
    SRC_LFT  = 2'd0,
    SRC_RGHT = 2'd1,
    SRC_BATT = 2'd2
  } src_t;

  localparam logic [10:0] CMD_PAD = 11'h000;

  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {2'b00, ch, CMD_PAD};
  endfunction

  function automatic src_t src_next(input src_t s);
    case (s)
      SRC_LFT:  return SRC_RGHT;
      SRC_RGHT: return SRC_BATT;
      default:  return SRC_LFT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_tout_tmr.sv
// Transaction watchdog: cleared on each SPI start, counts while enabled.
module a2d_tout_tmr #(
  parameter int TOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = $clog2(TOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Terminal count fires on the enabled cycle that would make the count reach TOUT_CYCLES.
  assign o_tc = i_en && (r_cnt == CNT_W'(TOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/a2d_conv_sched.sv
// Round-robin scheduler sharing one SPI monarch between the left/right load
// cells and the battery on the ADC128S; latches 12-bit results per source.
module a2d_conv_sched
  import a2d_pkg::*;
#(
  parameter logic [2:0] LFT_CH      = 3'd0,
  parameter logic [2:0] RGHT_CH     = 3'd4,
  parameter logic [2:0] BATT_CH     = 3'd5,
  parameter int         GAP_CYCLES  = 4,
  parameter int         TOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        upd_vld,
  output logic [1:0]  upd_ch,
  output logic        busy,
  output logic        ovr,
  output logic        tout_err
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  src_t               r_ptr;
  logic               r_pend;
  logic [15:0]        r_cmd;
  logic [GAP_W-1:0]   r_gap;
  logic [11:0]        r_data;
  logic [11:0]        r_lft;
  logic [11:0]        r_rght;
  logic [11:0]        r_batt;
  logic               r_ovr;
  logic               r_tout;
  logic               w_busy;
  logic               w_take;
  logic               w_abort;
  logic               w_tc;
  logic [2:0]         w_ch;
  logic               w_unused_hi;

  // The ADC only returns 12 result bits; the top nibble is don't-care.
  assign w_unused_hi = ^rd_data[15:12];

  assign w_busy   = (r_state != ST_IDLE);
  assign busy     = w_busy;
  assign wrt      = (r_state == ST_CMD) || (r_state == ST_READ);
  assign cmd      = r_cmd;
  assign upd_vld  = (r_state == ST_UPD);
  assign upd_ch   = r_ptr;
  assign lft_ld   = r_lft;
  assign rght_ld  = r_rght;
  assign batt     = r_batt;
  assign ovr      = r_ovr;
  assign tout_err = r_tout;

  always_comb begin
    w_ch = BATT_CH;
    case (r_ptr)
      SRC_LFT:  w_ch = LFT_CH;
      SRC_RGHT: w_ch = RGHT_CH;
      default:  w_ch = BATT_CH;
    endcase
  end

  a2d_tout_tmr #(.TOUT_CYCLES(TOUT_CYCLES)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (wrt),
    .i_en  ((r_state == ST_WAIT1) || (r_state == ST_WAIT2)),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (nxt || r_pend) begin
          w_state_nxt = ST_CMD;
          w_take      = 1'b1;
        end
      end
      ST_CMD:  w_state_nxt = ST_WAIT1;
      ST_WAIT1: begin
        if (done) begin
          w_state_nxt = ST_GAP;
        end else if (w_tc) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_W'(GAP_CYCLES - 1)) w_state_nxt = ST_READ;
      end
      ST_READ: w_state_nxt = ST_WAIT2;
      ST_WAIT2: begin
        if (done) begin
          w_state_nxt = ST_UPD;
        end else if (w_tc) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end
      end
      ST_UPD:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= SRC_LFT;
      r_pend  <= 1'b0;
      r_cmd   <= '0;
      r_gap   <= '0;
      r_data  <= '0;
      r_lft   <= '0;
      r_rght  <= '0;
      r_batt  <= '0;
      r_ovr   <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= (r_state == ST_GAP) ? r_gap + 1'b1 : '0;
      if (w_take) r_cmd <= mk_cmd(w_ch);
      // One-deep trigger queue; a trigger taken in IDLE alongside a pending one re-queues.
      if (w_busy) begin
        if (nxt) begin
          if (r_pend) r_ovr <= 1'b1;
          else        r_pend <= 1'b1;
        end
      end else if (w_take) begin
        r_pend <= r_pend & nxt;
      end
      if ((r_state == ST_WAIT2) && done) r_data <= rd_data[11:0];
      if (r_state == ST_UPD) begin
        case (r_ptr)
          SRC_LFT:  r_lft  <= r_data;
          SRC_RGHT: r_rght <= r_data;
          default:  r_batt <= r_data;
        endcase
      end
      if ((r_state == ST_UPD) || w_abort) r_ptr <= src_next(r_ptr);
      if (w_abort) r_tout <= 1'b1;
    end
  end

endmodule
